// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - branch/jump resolution FSM with comparator handshake and statistics
module branch_resolve_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic        req_is_jump,
  input  logic [31:0] req_pc,
  input  logic [31:0] req_target,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic [31:0] cmp_DataA,
  output logic [31:0] cmp_DataB,
  output logic        cmp_BrUn,
  input  logic        BrEq,
  input  logic        BrLT,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_taken,
  output logic        res_illegal,
  output logic [31:0] res_next_pc,
  output logic        flush,
  input  logic        stat_clr,
  output logic [15:0] stat_branches,
  output logic [15:0] stat_taken
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  funct3_q;
  logic        is_jump_q;
  logic [31:0] pc_q;
  logic [31:0] target_q;
  logic [31:0] data_a_q;
  logic [31:0] data_b_q;
  logic        br_eq_q;
  logic        br_lt_q;
  logic [15:0] stat_branches_q, stat_branches_d;
  logic [15:0] stat_taken_q, stat_taken_d;

  logic        accept;
  logic        handshake;
  logic        taken_raw;
  logic        illegal_raw;

  // Decode the captured instruction and latched comparator flags into a resolution
  always_comb begin
    taken_raw   = 1'b0;
    illegal_raw = 1'b0;
    if (is_jump_q) begin
      taken_raw = 1'b1;
    end else begin
      case (funct3_q)
        3'b000:          taken_raw = br_eq_q;
        3'b001:          taken_raw = !br_eq_q;
        3'b100, 3'b110:  taken_raw = br_lt_q;
        3'b101, 3'b111:  taken_raw = !br_lt_q;
        default:         illegal_raw = 1'b1;
      endcase
    end
  end

  // State register; reset drops any in-flight resolution
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake/output decode; resolution outputs read zero outside RESP
  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    cmp_BrUn    = 1'b0;
    res_valid   = 1'b0;
    res_taken   = 1'b0;
    res_illegal = 1'b0;
    res_next_pc = 32'd0;
    accept      = 1'b0;
    handshake   = 1'b0;
    flush       = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = req_is_jump ? RESP : CMP;
        end
      end
      CMP: begin
        cmp_BrUn = (funct3_q[2:1] == 2'b11);
        state_d  = RESP;
      end
      RESP: begin
        res_valid   = 1'b1;
        res_taken   = taken_raw;
        res_illegal = illegal_raw;
        res_next_pc = taken_raw ? target_q : (pc_q + 32'd4);
        if (res_ready) begin
          handshake = 1'b1;
          flush     = taken_raw;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the request on acceptance and the comparator flags at the end of CMP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      funct3_q  <= 3'd0;
      is_jump_q <= 1'b0;
      pc_q      <= 32'd0;
      target_q  <= 32'd0;
      data_a_q  <= 32'd0;
      data_b_q  <= 32'd0;
      br_eq_q   <= 1'b0;
      br_lt_q   <= 1'b0;
    end else begin
      if (accept) begin
        funct3_q  <= req_funct3;
        is_jump_q <= req_is_jump;
        pc_q      <= req_pc;
        target_q  <= req_target;
        data_a_q  <= req_rs1;
        data_b_q  <= req_rs2;
      end
      if (state_q == CMP) begin
        br_eq_q <= BrEq;
        br_lt_q <= BrLT;
      end
    end
  end

  // Saturating statistics; clear wins over a same-cycle increment
  always_comb begin
    stat_branches_d = stat_branches_q;
    stat_taken_d    = stat_taken_q;
    if (stat_clr) begin
      stat_branches_d = 16'd0;
      stat_taken_d    = 16'd0;
    end else if (handshake) begin
      if (!is_jump_q && !illegal_raw && (stat_branches_q != 16'hFFFF)) begin
        stat_branches_d = stat_branches_q + 16'd1;
      end
      if (taken_raw && (stat_taken_q != 16'hFFFF)) begin
        stat_taken_d = stat_taken_q + 16'd1;
      end
    end
  end

  // Statistics registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches_q <= 16'd0;
      stat_taken_q    <= 16'd0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_taken_q    <= stat_taken_d;
    end
  end

  assign cmp_DataA     = data_a_q;
  assign cmp_DataB     = data_b_q;
  assign stat_branches = stat_branches_q;
  assign stat_taken    = stat_taken_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - scoreboard bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic        req_is_jump;
  logic [31:0] req_pc;
  logic [31:0] req_target;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [31:0] cmp_DataA;
  logic [31:0] cmp_DataB;
  logic        cmp_BrUn;
  logic        BrEq;
  logic        BrLT;
  logic        res_valid;
  logic        res_ready;
  logic        res_taken;
  logic        res_illegal;
  logic [31:0] res_next_pc;
  logic        flush;
  logic        stat_clr;
  logic [15:0] stat_branches;
  logic [15:0] stat_taken;

  typedef struct packed {
    logic        taken;
    logic        illegal;
    logic [31:0] npc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  branch_resolve_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_funct3    (req_funct3),
    .req_is_jump   (req_is_jump),
    .req_pc        (req_pc),
    .req_target    (req_target),
    .req_rs1       (req_rs1),
    .req_rs2       (req_rs2),
    .cmp_DataA     (cmp_DataA),
    .cmp_DataB     (cmp_DataB),
    .cmp_BrUn      (cmp_BrUn),
    .BrEq          (BrEq),
    .BrLT          (BrLT),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_taken     (res_taken),
    .res_illegal   (res_illegal),
    .res_next_pc   (res_next_pc),
    .flush         (flush),
    .stat_clr      (stat_clr),
    .stat_branches (stat_branches),
    .stat_taken    (stat_taken)
  );

  // Comparator model fed from the registered operands
  assign BrEq = (cmp_DataA == cmp_DataB);
  assign BrLT = cmp_BrUn ? (cmp_DataA < cmp_DataB) : ($signed(cmp_DataA) < $signed(cmp_DataB));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every result handshake, checks flush elsewhere
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (res_valid && res_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got next_pc 0x%08h expected no result", res_next_pc);
          end else begin
            e = exp_q.pop_front();
            chk("res_taken", res_taken, e.taken);
            chk("res_illegal", res_illegal, e.illegal);
            chk("res_next_pc", res_next_pc, e.npc);
            chk("flush_hs", flush, e.taken);
          end
        end else begin
          chk("flush_idle", flush, 1'b0);
        end
      end
    end
  end

  task automatic do_req(input logic [2:0] f3, input logic jmp,
                        input logic [31:0] pc, input logic [31:0] tgt,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic exp_taken, input logic exp_ill,
                        input logic [31:0] exp_npc, input logic exp_brun,
                        input int hold, input logic clr_hs);
    exp_t e;
    e.taken   = exp_taken;
    e.illegal = exp_ill;
    e.npc     = exp_npc;
    exp_q.push_back(e);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1'b1);
    req_funct3  = f3;
    req_is_jump = jmp;
    req_pc      = pc;
    req_target  = tgt;
    req_rs1     = rs1;
    req_rs2     = rs2;
    req_valid   = 1'b1;
    res_ready   = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("cmp_DataA", cmp_DataA, rs1);
    chk("cmp_DataB", cmp_DataB, rs2);
    chk("req_ready_busy", req_ready, 1'b0);
    if (!jmp) begin
      chk("valid_in_cmp", res_valid, 1'b0);
      chk("cmp_BrUn", cmp_BrUn, exp_brun);
      @(negedge clk);
    end
    chk("latency_valid", res_valid, 1'b1);
    chk("brun_outside_cmp", cmp_BrUn, 1'b0);
    for (int i = 0; i < hold; i++) begin
      chk("hold_taken", res_taken, exp_taken);
      chk("hold_npc", res_next_pc, exp_npc);
      chk("hold_req_ready", req_ready, 1'b0);
      chk("hold_flush", flush, 1'b0);
      @(negedge clk);
      chk("hold_valid", res_valid, 1'b1);
    end
    res_ready = 1'b1;
    stat_clr  = clr_hs;
    @(posedge clk);
    @(negedge clk);
    stat_clr = 1'b0;
    chk("valid_after_hs", res_valid, 1'b0);
    chk("ready_after_hs", req_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_funct3  = 3'd0;
    req_is_jump = 1'b0;
    req_pc      = 32'd0;
    req_target  = 32'd0;
    req_rs1     = 32'd0;
    req_rs2     = 32'd0;
    res_ready   = 1'b0;
    stat_clr    = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_flush", flush, 1'b0);
    chk("rst_dataA", cmp_DataA, 32'd0);
    chk("rst_dataB", cmp_DataB, 32'd0);
    chk("rst_brun", cmp_BrUn, 1'b0);
    chk("rst_stat_br", stat_branches, 16'd0);
    chk("rst_stat_tk", stat_taken, 16'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);

    // BLT signed -1 < 1: taken
    do_req(3'b100, 1'b0, 32'h0000_0100, 32'h0000_0200, 32'hFFFF_FFFF, 32'd1,
           1'b1, 1'b0, 32'h0000_0200, 1'b0, 0, 1'b0);
    chk("blt_stat_br", stat_branches, 16'd1);
    chk("blt_stat_tk", stat_taken, 16'd1);

    // BGEU unsigned 0xFFFFFFFF >= 1: taken
    do_req(3'b111, 1'b0, 32'h0000_0104, 32'h0000_0080, 32'hFFFF_FFFF, 32'd1,
           1'b1, 1'b0, 32'h0000_0080, 1'b1, 0, 1'b0);
    chk("bgeu_stat_br", stat_branches, 16'd2);
    chk("bgeu_stat_tk", stat_taken, 16'd2);

    // BEQ not taken at top of address space: pc+4 wraps to 0
    do_req(3'b000, 1'b0, 32'hFFFF_FFFC, 32'h0000_0040, 32'd5, 32'd6,
           1'b0, 1'b0, 32'h0000_0000, 1'b0, 0, 1'b0);
    chk("beq_stat_br", stat_branches, 16'd3);
    chk("beq_stat_tk", stat_taken, 16'd2);

    // JAL with funct3 bits that would be illegal for a branch, consumer stalls 3 cycles
    do_req(3'b010, 1'b1, 32'h0000_1000, 32'h0000_2000, 32'd9, 32'd10,
           1'b1, 1'b0, 32'h0000_2000, 1'b0, 3, 1'b0);
    chk("jal_stat_br", stat_branches, 16'd3);
    chk("jal_stat_tk", stat_taken, 16'd3);

    // Illegal funct3 010: not taken, no counter change
    do_req(3'b010, 1'b0, 32'h0000_0300, 32'h0000_0500, 32'd7, 32'd7,
           1'b0, 1'b1, 32'h0000_0304, 1'b0, 0, 1'b0);
    chk("ill_stat_br", stat_branches, 16'd3);
    chk("ill_stat_tk", stat_taken, 16'd3);

    // BNE equal operands: not taken
    do_req(3'b001, 1'b0, 32'h0000_0010, 32'h0000_0900, 32'd1, 32'd1,
           1'b0, 1'b0, 32'h0000_0014, 1'b0, 0, 1'b0);
    // BLTU 1 < 0xFFFFFFFF unsigned: taken
    do_req(3'b110, 1'b0, 32'h0000_0020, 32'h0000_0A00, 32'd1, 32'hFFFF_FFFF,
           1'b1, 1'b0, 32'h0000_0A00, 1'b1, 0, 1'b0);
    // BGE signed -1 >= 1 false: not taken
    do_req(3'b101, 1'b0, 32'h0000_0030, 32'h0000_0B00, 32'hFFFF_FFFF, 32'd1,
           1'b0, 1'b0, 32'h0000_0034, 1'b0, 0, 1'b0);
    chk("mix_stat_br", stat_branches, 16'd6);
    chk("mix_stat_tk", stat_taken, 16'd4);

    // Reset while in CMP discards the pending taken branch
    @(negedge clk);
    req_funct3  = 3'b000;
    req_is_jump = 1'b0;
    req_pc      = 32'h0000_0040;
    req_target  = 32'h0000_0080;
    req_rs1     = 32'd3;
    req_rs2     = 32'd3;
    req_valid   = 1'b1;
    res_ready   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_rst_in_cmp", res_valid, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", res_valid, 1'b0);
    chk("midrst_flush", flush, 1'b0);
    chk("midrst_dataA", cmp_DataA, 32'd0);
    chk("midrst_stat_br", stat_branches, 16'd0);
    chk("midrst_stat_tk", stat_taken, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_valid", res_valid, 1'b0);
    chk("postrst_ready", req_ready, 1'b1);
    @(negedge clk);
    chk("postrst_valid2", res_valid, 1'b0);
    chk("postrst_stat_tk", stat_taken, 16'd0);

    // Preload counters to saturation, then a taken branch must not wrap
    force dut.stat_branches_q = 16'hFFFF;
    force dut.stat_taken_q    = 16'hFFFF;
    #1;
    release dut.stat_branches_q;
    release dut.stat_taken_q;
    do_req(3'b000, 1'b0, 32'h0000_0600, 32'h0000_0700, 32'd4, 32'd4,
           1'b1, 1'b0, 32'h0000_0700, 1'b0, 0, 1'b0);
    chk("sat_stat_br", stat_branches, 16'hFFFF);
    chk("sat_stat_tk", stat_taken, 16'hFFFF);

    // Clear on the same cycle as a taken handshake: clear wins
    do_req(3'b001, 1'b0, 32'h0000_0800, 32'h0000_0C00, 32'd1, 32'd2,
           1'b1, 1'b0, 32'h0000_0C00, 1'b0, 0, 1'b1);
    chk("clr_stat_br", stat_branches, 16'd0);
    chk("clr_stat_tk", stat_taken, 16'd0);

    // Counting resumes from zero
    do_req(3'b001, 1'b0, 32'h0000_0810, 32'h0000_0D00, 32'd1, 32'd2,
           1'b1, 1'b0, 32'h0000_0D00, 1'b0, 0, 1'b0);
    chk("resume_stat_br", stat_branches, 16'd1);
    chk("resume_stat_tk", stat_taken, 16'd1);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  1  decoder offers a branch/jump.
REQ-005 req_ready  out  1  block can accept a request.
REQ-006 req_funct3  in  3  RV32I branch funct3.
REQ-007 req_is_jump  in  1  unconditional JAL/JALR; funct3 is ignored.
REQ-008 req_pc, req_target  in  32 each  instruction PC and precomputed target.
REQ-009 req_rs1, req_rs2  in  32 each  source operands.
REQ-010 cmp_DataA, cmp_DataB  out  32 each  registered operands driven to the comparator.
REQ-011 cmp_BrUn  out  1  unsigned-compare select for the comparator.
REQ-012 BrEq, BrLT  in  1 each  comparator results (combinational from cmp_*).
REQ-013 res_valid  out  1  resolution available; res_ready  in  1  consumer accepts it.
REQ-014 res_taken  out  1; res_illegal  out  1; res_next_pc  out  32.
REQ-015 flush  out  1  one-cycle pipeline flush pulse.
REQ-016 stat_clr  in  1; stat_branches  out  16; stat_taken  out  16.

Function
REQ-017 The FSM SHALL have three states: IDLE, CMP and RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1.
REQ-019 On acceptance, the block SHALL register funct3, is_jump, pc, target, rs1→cmp_DataA and rs2→cmp_DataB, then go to CMP (branch) or RESP (jump).
REQ-020 In CMP, cmp_BrUn SHALL be 1 for funct3 110/111 and 0 otherwise; it SHALL be stable for the whole cycle.
REQ-021 At the end of CMP, the block SHALL register BrEq and BrLT and go to RESP.
REQ-022 Taken decode SHALL be: 000 BrEq; 001 !BrEq; 100/110 BrLT; 101/111 !BrLT; jump always 1.
REQ-023 funct3 010 or 011 SHALL give res_illegal=1 and res_taken=0.
REQ-024 res_next_pc SHALL be the target when taken, else pc+4 (mod 2^32, so wrap-around is allowed).
REQ-025 In RESP, res_valid=1 and all res_* outputs SHALL hold stable until res_ready=1; the FSM then returns to IDLE.
REQ-026 Latency from acceptance at cycle T SHALL be: branch res_valid at T+2; jump res_valid at T+1.
REQ-027 flush SHALL be 1 for exactly the handshake cycle (res_valid and res_ready) of a taken resolution, and 0 otherwise.
REQ-028 No new request SHALL be accepted during CMP or RESP; back-to-back branches have a minimum 3-cycle spacing.
REQ-029 stat_branches SHALL increment at each non-jump, non-illegal handshake.
REQ-030 stat_taken SHALL increment at each taken handshake, including jumps.
REQ-031 Both counters SHALL saturate at 0xFFFF.
REQ-032 stat_clr SHALL zero both counters and SHALL take priority over a same-cycle increment.
REQ-033 cmp_BrUn SHALL be 0 outside CMP; cmp_DataA and cmp_DataB SHALL hold their last captured values.

Reset
REQ-034 Reset SHALL immediately force IDLE and clear all registers.
REQ-035 Reset values SHALL be: req_ready=1 (once rst deasserts); res_*=0; flush=0; cmp_*=0; counters=0.
REQ-036 A reset during CMP or RESP SHALL discard the pending resolution with no flush and no counter update.

Verification
REQ-037 BLT with rs1=0xFFFFFFFF, rs2=1, BrLT=1, res_ready=1 -> cmp_BrUn=0 in CMP; res_taken=1; next_pc=target; flush pulse at T+2; stat_taken=1.
REQ-038 BGEU with rs1=0xFFFFFFFF, rs2=1, BrLT=0 -> cmp_BrUn=1; res_taken=1; stat_branches=1, stat_taken=1.
REQ-039 BEQ not taken at pc=0xFFFFFFFC -> res_next_pc=0x00000000; flush stays 0.
REQ-040 JAL with res_ready held 0 for 3 cycles -> res_valid from T+1, outputs stable, req_ready=0; flush only on the handshake cycle.
REQ-041 funct3=010 -> res_illegal=1, res_taken=0, next_pc=pc+4; no counter changes.
REQ-042 rst pulse mid-CMP, then counters preloaded to 0xFFFF with stat_clr asserted on an increment cycle -> block returns to IDLE with no flush; saturation holds at 0xFFFF; clr yields 0.
